paralelo_serial: RTL

//  Byte-to-bit serializer; transmit end of the PHY lane feeding the serial_paralelo receiver.

---
 rtl/paralelo_serial.sv | 102 ++++++++++
 1 files changed

// File: rtl/paralelo_serial.sv
// paralelo_serial: byte-to-bit serializer with comma training and comma idle fill, MSB first.
// Optional: define PS_BC_FILTER_EN to drop payload bytes equal to COMMA (adds the bc_drop port).
module paralelo_serial #(
  parameter logic [7:0] COMMA       = 8'hBC,
  parameter int         TRAIN_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       active_out,
`ifdef PS_BC_FILTER_EN
  output logic       bc_drop,
`endif
  output logic       byte_start
);

  localparam int              TCW        = $clog2(TRAIN_COUNT + 1);
  localparam logic [TCW-1:0]  TRAIN_LAST = TCW'(TRAIN_COUNT - 1);

  typedef enum logic {TRAIN, ACTIVE} state_t;

  state_t         state;
  logic [2:0]     bit_cnt;
  logic [TCW-1:0] train_cnt;
  logic [7:0]     shreg;
  logic [7:0]     hold;
  logic           hold_full;
  logic [7:0]     tx_byte;
  logic           accept;
  logic           store;
  logic           load;

  assign ready_out = ~reset & ~hold_full;
  assign accept    = valid_in & ready_out;
  assign load      = (bit_cnt == 3'd0);

`ifdef PS_BC_FILTER_EN
  assign store = accept & (data_in != COMMA);
`else
  assign store = accept;
`endif

  // Held payload is only sent once training is over; otherwise the slot is filled with COMMA.
  always_comb begin
    tx_byte = COMMA;
    if (state == ACTIVE && hold_full) tx_byte = hold;
  end

  // NOTE: hold is pure datapath qualified by hold_full, so it needs no reset.
  always_ff @(posedge clk_32f) begin
    if (store) hold <= data_in;
  end

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state      <= TRAIN;
      bit_cnt    <= 3'd0;
      train_cnt  <= '0;
      shreg      <= 8'h00;
      hold_full  <= 1'b0;
      data_out   <= 1'b0;
      byte_start <= 1'b0;
      active_out <= 1'b0;
`ifdef PS_BC_FILTER_EN
      bc_drop    <= 1'b0;
`endif
    end else begin
      bit_cnt <= bit_cnt + 3'd1;

      if (load) begin
        data_out   <= tx_byte[7];
        shreg      <= {tx_byte[6:0], 1'b0};
        byte_start <= 1'b1;
        if (state == TRAIN) begin
          train_cnt <= train_cnt + 1'b1;
          if (train_cnt == TRAIN_LAST) begin
            state      <= ACTIVE;
            active_out <= 1'b1;
          end
        end else if (hold_full) begin
          hold_full <= 1'b0;
        end
      end else begin
        data_out   <= shreg[7];
        shreg      <= {shreg[6:0], 1'b0};
        byte_start <= 1'b0;
      end

      // Accept only happens with hold empty, so it never races the load-side clear above.
      if (store) hold_full <= 1'b1;

`ifdef PS_BC_FILTER_EN
      bc_drop <= accept & (data_in == COMMA);
`endif
    end
  end

endmodule
